// File: rtl/hmmm_pkg.sv
// ============================================================================
// Module      : hmmm_pkg
// Description : Shared constants and loader state encoding for the hmmm core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hmmm_pkg;

    localparam int         HMMM_BUS_W     = 16;
    localparam logic [7:0] HMMM_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_LEN   = 3'd1,
        LDR_HI    = 3'd2,
        LDR_LO    = 3'd3,
        LDR_ADDR  = 3'd4,
        LDR_DATA  = 3'd5,
        LDR_CKSUM = 3'd6,
        LDR_BOOT  = 3'd7
    } ldr_state_t;

endpackage

`default_nettype wire

// File: rtl/hmmm_loader_timeout.sv
// ============================================================================
// Module      : hmmm_loader_timeout
// Description : Inter-byte idle watchdog; reloads on kick or when disabled,
//               expires after TIMEOUT_CYC consecutive idle enabled cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hmmm_loader_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_disabled
            logic unused_ok;
            assign unused_ok = ^{clk, rst, kick_i, en_i};
            assign expire_o  = 1'b0;
        end else begin : g_enabled
            localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    cnt_q <= CW'(TIMEOUT_CYC);
                end else if (!en_i || kick_i) begin
                    cnt_q <= CW'(TIMEOUT_CYC);
                end else if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end

            // Fires on the TIMEOUT_CYC-th idle cycle so the caller leaves on that edge.
            assign expire_o = en_i && !kick_i && (cnt_q == CW'(1));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/hmmm_loader.sv
// ============================================================================
// Module      : hmmm_loader
// Description : Framed byte-stream program loader driving the hmmm core bus.
//               Optional trailing checksum: define HMMM_LOADER_CKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hmmm_loader
    import hmmm_pkg::*;
#(
    parameter int         ADDR_W      = 8,
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] SYNC_BYTE   = HMMM_SYNC_BYTE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic [HMMM_BUS_W-1:0] bus_out,
    output logic                  bus_oe,
    output logic                  pgrm_addr,
    output logic                  pgrm_data,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  err
);

`ifdef HMMM_LOADER_CKSUM_EN
    localparam ldr_state_t TAIL_STATE = LDR_CKSUM;
`else
    localparam ldr_state_t TAIL_STATE = LDR_BOOT;
`endif

    ldr_state_t                state_q, state_d;
    logic [ADDR_W-1:0]         len_q, len_d;
    logic [ADDR_W-1:0]         cnt_q, cnt_d;
    logic [HMMM_BUS_W-1:0]     word_q, word_d;
    logic                      err_q, err_d;
    logic [ADDR_W-1:0]         cnt_inc;
    logic                      accept;
    logic                      waiting;
    logic                      expire;
`ifdef HMMM_LOADER_CKSUM_EN
    logic                      hold_q, hold_d;
    logic [7:0]                cks_q, cks_d;
`endif

    assign in_ready = (state_q == LDR_IDLE) || (state_q == LDR_LEN) ||
                      (state_q == LDR_HI)   || (state_q == LDR_LO)  ||
                      (state_q == LDR_CKSUM);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != LDR_IDLE);
    assign err      = err_q;
    assign cnt_inc  = cnt_q + ADDR_W'(1);

    // Only byte-waiting states are watched; a failed-checksum hold waits forever.
`ifdef HMMM_LOADER_CKSUM_EN
    assign waiting = (state_q == LDR_LEN) || (state_q == LDR_HI) ||
                     (state_q == LDR_LO)  || ((state_q == LDR_CKSUM) && !hold_q);
`else
    assign waiting = (state_q == LDR_LEN) || (state_q == LDR_HI) ||
                     (state_q == LDR_LO);
`endif

    hmmm_loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .kick_i   (accept),
        .en_i     (waiting),
        .expire_o (expire)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        err_d     = err_q;
        bus_out   = '0;
        bus_oe    = 1'b0;
        pgrm_addr = 1'b0;
        pgrm_data = 1'b0;
        cpu_rst   = 1'b0;
`ifdef HMMM_LOADER_CKSUM_EN
        hold_d    = hold_q;
        cks_d     = cks_q;
`endif

        case (state_q)
            LDR_IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) begin
                    state_d = LDR_LEN;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            LDR_LEN: begin
                if (accept) begin
                    len_d   = ADDR_W'(in_data);
                    state_d = (in_data == 8'd0) ? TAIL_STATE : LDR_HI;
`ifdef HMMM_LOADER_CKSUM_EN
                    cks_d   = in_data;
`endif
                end
            end
            LDR_HI: begin
                if (accept) begin
                    word_d[15:8] = in_data;
                    state_d      = LDR_LO;
`ifdef HMMM_LOADER_CKSUM_EN
                    cks_d        = cks_q ^ in_data;
`endif
                end
            end
            LDR_LO: begin
                if (accept) begin
                    word_d[7:0] = in_data;
                    state_d     = LDR_ADDR;
`ifdef HMMM_LOADER_CKSUM_EN
                    cks_d       = cks_q ^ in_data;
`endif
                end
            end
            LDR_ADDR: begin
                bus_out   = HMMM_BUS_W'(cnt_q);
                bus_oe    = 1'b1;
                pgrm_addr = 1'b1;
                state_d   = LDR_DATA;
            end
            LDR_DATA: begin
                bus_out   = word_q;
                bus_oe    = 1'b1;
                pgrm_data = 1'b1;
                cnt_d     = cnt_inc;
                state_d   = (cnt_inc == len_q) ? TAIL_STATE : LDR_HI;
            end
`ifdef HMMM_LOADER_CKSUM_EN
            LDR_CKSUM: begin
                // After a mismatch the core is held in reset until the host resyncs.
                if (hold_q) begin
                    cpu_rst = 1'b1;
                    if (accept && (in_data == SYNC_BYTE)) begin
                        state_d = LDR_IDLE;
                        hold_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end else if (accept) begin
                    if (in_data == cks_q) begin
                        state_d = LDR_BOOT;
                    end else begin
                        err_d  = 1'b1;
                        hold_d = 1'b1;
                    end
                end
            end
`endif
            LDR_BOOT: begin
                cpu_rst = 1'b1;
                state_d = LDR_IDLE;
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase

        if (expire) begin
            state_d = LDR_IDLE;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LDR_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            err_q   <= 1'b0;
`ifdef HMMM_LOADER_CKSUM_EN
            hold_q  <= 1'b0;
            cks_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            err_q   <= err_d;
`ifdef HMMM_LOADER_CKSUM_EN
            hold_q  <= hold_d;
            cks_q   <= cks_d;
`endif
        end
    end

endmodule

`default_nettype wire
